bi_input_sequencer: RTL



---
 rtl/bi_input_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bi_input_sequencer.sv
// Input binarization sequencer: fetches KERNEL_SIZE pixels per window from SRAM,
// freezes them in a buffer and streams the thermometer-coded window downstream.

module binarization_input #(
    parameter int KERNEL_SIZE = 9,
    parameter int BIT_WIDTH   = 8,
    parameter int CHANNEL_CNT = 256
) (
    input  logic [KERNEL_SIZE*BIT_WIDTH-1:0]   pixels,
    output logic [KERNEL_SIZE*CHANNEL_CNT-1:0] bits
);
    // Channel c of a slot is set when the pixel exceeds c: pixel p yields p ones.
    for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_slot
        for (genvar c = 0; c < CHANNEL_CNT; c++) begin : g_chan
            assign bits[k*CHANNEL_CNT + c] = (32'(pixels[k*BIT_WIDTH +: BIT_WIDTH]) > c);
        end
    end
endmodule

module bi_input_sequencer #(
    parameter int KERNEL_SIZE = 9,
    parameter int BIT_WIDTH   = 8,
    parameter int CHANNEL_CNT = 256,
    parameter int ADDR_W      = 16,
    parameter int CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [ADDR_W-1:0]                  base_addr,
    input  logic [CNT_W-1:0]                   num_windows,
    output logic                               rd_en,
    output logic [ADDR_W-1:0]                  rd_addr,
    input  logic [BIT_WIDTH-1:0]               rd_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [KERNEL_SIZE*CHANNEL_CNT-1:0] out_data,
    output logic                               busy,
    output logic                               done
);
    localparam int K_W = $clog2(KERNEL_SIZE);

    typedef enum logic [2:0] {IDLE, FETCH, CAPT, OUT, FIN} state_t;

    state_t                                state, state_d;
    logic [ADDR_W-1:0]                     base_q;
    logic [CNT_W-1:0]                      num_q;
    logic [CNT_W-1:0]                      win;
    logic [K_W-1:0]                        k;
    logic                                  rd_vld;
    logic [K_W-1:0]                        wr_slot;
    logic [KERNEL_SIZE-1:0][BIT_WIDTH-1:0] pix_buf;
    logic [ADDR_W-1:0]                     fetch_addr;
    logic                                  last_win;

    assign fetch_addr = base_q + ADDR_W'(win * KERNEL_SIZE) + ADDR_W'(k);
    assign last_win   = (CNT_W'(win + CNT_W'(1)) == num_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // NOTE: every output and next-state is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_d   = state;
        rd_en     = 1'b0;
        rd_addr   = '0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_d = (num_windows == '0) ? FIN : FETCH;
            end
            FETCH: begin
                rd_en   = 1'b1;
                rd_addr = fetch_addr;
                if (k == K_W'(KERNEL_SIZE - 1)) state_d = CAPT;
            end
            CAPT: state_d = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = last_win ? FIN : FETCH;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the pixel buffer is a handful of flops, not a RAM macro, so it is reset along with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            num_q   <= '0;
            win     <= '0;
            k       <= '0;
            rd_vld  <= 1'b0;
            wr_slot <= '0;
            pix_buf <= '0;
        end else begin
            // Read data returns one cycle after the strobe, tagged with the slot it was issued for.
            rd_vld  <= rd_en;
            wr_slot <= k;
            if (rd_vld) pix_buf[wr_slot] <= rd_data;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        num_q  <= num_windows;
                        win    <= '0;
                        k      <= '0;
                    end
                end
                FETCH: k <= k + K_W'(1);
                OUT: begin
                    if (out_ready) begin
                        win <= win + CNT_W'(1);
                        k   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    binarization_input #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .BIT_WIDTH   (BIT_WIDTH),
        .CHANNEL_CNT (CHANNEL_CNT)
    ) u_bin (
        .pixels (pix_buf),
        .bits   (out_data)
    );
endmodule
